// File: rtl/attractor_sweep_ctrl_pkg.sv
// Shared types for the Boolean-network attractor sweep: result kinds, FSM states, defaults.
package gene_net_pkg;

   localparam int N_GENES_DEFAULT   = 8;
   localparam int MAX_STEPS_DEFAULT = 16;

   typedef enum logic [1:0] {
      KIND_NONE    = 2'b00,
      KIND_FIXED   = 2'b01,
      KIND_CYCLE   = 2'b10,
      KIND_TIMEOUT = 2'b11
   } kind_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_SETTLE,
      ST_RUN,
      ST_REPORT,
      ST_DONE
   } fsm_t;

endpackage

// File: rtl/attractor_sweep_ctrl_if.sv
// Result channel from the sweep controller to the logger; valid/ready, fields held while stalled.
interface attractor_sweep_ctrl_if
   import gene_net_pkg::*;
#(
   parameter int N_GENES = N_GENES_DEFAULT,
   parameter int STEP_W  = $clog2(MAX_STEPS_DEFAULT + 1)
);
   logic                res_valid;
   logic                res_ready;
   logic [N_GENES-1:0]  res_init;
   logic [N_GENES-1:0]  res_attr;
   kind_t               res_kind;
   logic [STEP_W-1:0]   res_steps;

   modport master (
      output res_valid, res_init, res_attr, res_kind, res_steps,
      input  res_ready
   );

   modport slave (
      input  res_valid, res_init, res_attr, res_kind, res_steps,
      output res_ready
   );
endinterface

// File: rtl/attractor_sweep_ctrl_detect.sv
// Trajectory history (s1, s2), step counter and fixed/2-cycle/timeout classification.
// Combinational hit/kind from the current network state; history updates only on non-hit RUN cycles.
module attractor_detect
   import gene_net_pkg::*;
#(
   parameter int N_GENES   = N_GENES_DEFAULT,
   parameter int MAX_STEPS = MAX_STEPS_DEFAULT,
   parameter int STEP_W    = $clog2(MAX_STEPS + 1)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               clear,
   input  logic               capture,
   input  logic               active,
   input  logic [N_GENES-1:0] net_state,
   output logic               hit,
   output kind_t              kind,
   output logic [STEP_W-1:0]  step
);
   logic [N_GENES-1:0] s1;
   logic [N_GENES-1:0] s2;
   logic               is_fixed;
   logic               is_cycle;
   logic               is_timeout;

   assign is_fixed   = (net_state == s1);
   assign is_cycle   = (step >= STEP_W'(2)) && (net_state == s2) && !is_fixed;
   assign is_timeout = (step == STEP_W'(MAX_STEPS));

   always_comb begin
      kind = KIND_NONE;
      if (is_fixed)        kind = KIND_FIXED;
      else if (is_cycle)   kind = KIND_CYCLE;
      else if (is_timeout) kind = KIND_TIMEOUT;
      hit = active && (kind != KIND_NONE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1   <= '0;
         s2   <= '0;
         step <= '0;
      end else if (clear) begin
         step <= '0;
      end else if (capture) begin
         s1   <= net_state;
         step <= STEP_W'(1);
      end else if (active && !hit) begin
         s2   <= s1;
         s1   <= net_state;
         step <= step + STEP_W'(1);
      end
   end
endmodule

// File: rtl/attractor_sweep_ctrl.sv
// Sweeps all 2^N_GENES initial states through the network, one classified result each (4 cycles min per state).
// Result held under backpressure with the network frozen; ATTRACTOR_STATS_EN adds per-kind result counters.
module attractor_sweep_ctrl
   import gene_net_pkg::*;
#(
   parameter int N_GENES   = N_GENES_DEFAULT,
   parameter int MAX_STEPS = MAX_STEPS_DEFAULT,
   parameter int STEP_W    = $clog2(MAX_STEPS + 1)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   output logic                   net_load,
   output logic [N_GENES-1:0]     net_init,
   output logic                   net_en,
   input  logic [N_GENES-1:0]     net_state,
   attractor_sweep_ctrl_if.master res,
   output logic                   busy,
   output logic                   done
`ifdef ATTRACTOR_STATS_EN
   ,
   output logic [N_GENES:0]       cnt_fixed,
   output logic [N_GENES:0]       cnt_cycle,
   output logic [N_GENES:0]       cnt_timeout
`endif
);
   fsm_t               state;
   logic [N_GENES-1:0] cur_init;
   logic               hit;
   kind_t              kind;
   logic [STEP_W-1:0]  step;
   logic               accept;

   assign accept = (state == ST_REPORT) && res.res_ready;

   // The detection cycle must not advance the network, so net_en cannot wait a clock for hit.
   assign net_en = (state == ST_SETTLE) || ((state == ST_RUN) && !hit);

   attractor_detect #(
      .N_GENES   (N_GENES),
      .MAX_STEPS (MAX_STEPS),
      .STEP_W    (STEP_W)
   ) u_detect (
      .clk       (clk),
      .rst       (rst),
      .clear     (state == ST_LOAD),
      .capture   (state == ST_SETTLE),
      .active    (state == ST_RUN),
      .net_state (net_state),
      .hit       (hit),
      .kind      (kind),
      .step      (step)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= ST_IDLE;
         cur_init      <= '0;
         net_load      <= 1'b0;
         net_init      <= '0;
         busy          <= 1'b0;
         done          <= 1'b0;
         res.res_valid <= 1'b0;
         res.res_init  <= '0;
         res.res_attr  <= '0;
         res.res_kind  <= KIND_NONE;
         res.res_steps <= '0;
      end else begin
         net_load <= 1'b0;
         done     <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  cur_init <= '0;
                  net_init <= '0;
                  net_load <= 1'b1;
                  busy     <= 1'b1;
                  state    <= ST_LOAD;
               end
            end
            ST_LOAD:   state <= ST_SETTLE;
            ST_SETTLE: state <= ST_RUN;
            ST_RUN: begin
               if (hit) begin
                  res.res_valid <= 1'b1;
                  res.res_init  <= cur_init;
                  res.res_attr  <= net_state;
                  res.res_kind  <= kind;
                  res.res_steps <= step;
                  state         <= ST_REPORT;
               end
            end
            ST_REPORT: begin
               if (accept) begin
                  res.res_valid <= 1'b0;
                  if (cur_init == '1) begin
                     done  <= 1'b1;
                     busy  <= 1'b0;
                     state <= ST_DONE;
                  end else begin
                     cur_init <= cur_init + N_GENES'(1);
                     net_init <= cur_init + N_GENES'(1);
                     net_load <= 1'b1;
                     state    <= ST_LOAD;
                  end
               end
            end
            ST_DONE:  state <= ST_IDLE;
            default:  state <= ST_IDLE;
         endcase
      end
   end

`ifdef ATTRACTOR_STATS_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_fixed   <= '0;
         cnt_cycle   <= '0;
         cnt_timeout <= '0;
      end else if ((state == ST_IDLE) && start) begin
         cnt_fixed   <= '0;
         cnt_cycle   <= '0;
         cnt_timeout <= '0;
      end else if (accept) begin
         case (res.res_kind)
            KIND_FIXED:   cnt_fixed   <= cnt_fixed   + 1'b1;
            KIND_CYCLE:   cnt_cycle   <= cnt_cycle   + 1'b1;
            KIND_TIMEOUT: cnt_timeout <= cnt_timeout + 1'b1;
            default:      ;
         endcase
      end
   end
`endif
endmodule

// File: tb/tb_attractor_sweep_ctrl.sv
// Bench: behavioural network (identity / inverter / incrementer) and a scoreboard of closed-form expected results.
module tb_attractor_sweep_ctrl;
   import gene_net_pkg::*;

   localparam int N  = 8;
   localparam int SW = 5;

   typedef struct {
      logic [N-1:0]  init;
      logic [N-1:0]  attr;
      logic [1:0]    kind;
      logic [SW-1:0] steps;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic         net_load;
   logic [N-1:0] net_init;
   logic         net_en;
   logic [N-1:0] net_state;
   logic         busy;
   logic         done;
`ifdef ATTRACTOR_STATS_EN
   logic [N:0]   cnt_fixed;
   logic [N:0]   cnt_cycle;
   logic [N:0]   cnt_timeout;
`endif

   int   mode;
   int   n_cmp = 0;
   int   n_err = 0;
   exp_t sb[$];

   attractor_sweep_ctrl_if #(.N_GENES(N), .STEP_W(SW)) rif ();

   attractor_sweep_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .net_load  (net_load),
      .net_init  (net_init),
      .net_en    (net_en),
      .net_state (net_state),
      .res       (rif),
      .busy      (busy),
      .done      (done)
`ifdef ATTRACTOR_STATS_EN
      ,
      .cnt_fixed   (cnt_fixed),
      .cnt_cycle   (cnt_cycle),
      .cnt_timeout (cnt_timeout)
`endif
   );

   always #5 clk = ~clk;

   always @(posedge clk or posedge rst) begin
      if (rst)           net_state <= '0;
      else if (net_load) net_state <= net_init;
      else if (net_en) begin
         case (mode)
            0:       net_state <= net_state;
            1:       net_state <= ~net_state;
            default: net_state <= net_state + 8'd1;
         endcase
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic exp_t expect_for(input int m, input logic [N-1:0] init);
      exp_t e;
      e.init = init;
      case (m)
         0:       begin e.attr = init;         e.kind = 2'b01; e.steps = 5'd1;  end
         1:       begin e.attr = init;         e.kind = 2'b10; e.steps = 5'd2;  end
         default: begin e.attr = init + 8'd16; e.kind = 2'b11; e.steps = 5'd16; end
      endcase
      return e;
   endfunction

   task automatic chk_reset_outputs(input string pfx);
      chk({pfx, "_net_load"},  net_load, 0);
      chk({pfx, "_net_en"},    net_en, 0);
      chk({pfx, "_net_init"},  net_init, 0);
      chk({pfx, "_busy"},      busy, 0);
      chk({pfx, "_done"},      done, 0);
      chk({pfx, "_res_valid"}, rif.res_valid, 0);
      chk({pfx, "_res_init"},  rif.res_init, 0);
      chk({pfx, "_res_attr"},  rif.res_attr, 0);
      chk({pfx, "_res_kind"},  rif.res_kind, 0);
      chk({pfx, "_res_steps"}, rif.res_steps, 0);
   endtask

   task automatic run_sweep(input int m, input int bp_init, input int abort_init);
      int   next_init = 0;
      int   last_load = -1;
      int   load_cyc  = 0;
      int   results   = 0;
      int   done_cnt  = 0;
      int   bp_cnt    = 0;
      bit   bp_follow = 1'b0;
      bit   finished  = 1'b0;
      exp_t e;
      exp_t snap;
      mode = m;
      sb.delete();
      @(negedge clk);
      start         = 1'b1;
      rif.res_ready = 1'b1;
      for (int cyc = 0; cyc < 8000 && !finished; cyc++) begin
         @(negedge clk);
         // A start pulse deep inside the sweep must not restart it.
         start = (cyc == 100);
         if (net_load) begin
            chk("load_order", net_init, next_init[7:0]);
            if (bp_follow) begin
               chk("bp_next_init", net_init, bp_init + 1);
               bp_follow = 1'b0;
            end
            sb.push_back(expect_for(m, net_init));
            last_load = int'(net_init);
            load_cyc  = cyc;
            next_init++;
         end
         if (abort_init >= 0 && last_load == abort_init && cyc == load_cyc + 2) begin
            chk("abort_in_run", net_en, 1);
            rst = 1'b1;
            #1;
            chk_reset_outputs("abort");
            @(negedge clk);
            rst = 1'b0;
            return;
         end
         rif.res_ready = 1'b1;
         if (rif.res_valid && int'(rif.res_init) == bp_init && bp_cnt < 5) begin
            if (bp_cnt == 0) begin
               snap.init = rif.res_init;  snap.attr  = rif.res_attr;
               snap.kind = rif.res_kind;  snap.steps = rif.res_steps;
            end else begin
               chk("bp_hold_init",  rif.res_init,  snap.init);
               chk("bp_hold_attr",  rif.res_attr,  snap.attr);
               chk("bp_hold_kind",  rif.res_kind,  snap.kind);
               chk("bp_hold_steps", rif.res_steps, snap.steps);
            end
            chk("bp_net_en",   net_en, 0);
            chk("bp_net_load", net_load, 0);
            rif.res_ready = 1'b0;
            bp_cnt++;
         end
         if (rif.res_valid && rif.res_ready) begin
            if (results == 0 && m == 0) chk("latency", cyc - load_cyc, 3);
            if (bp_cnt == 5 && int'(rif.res_init) == bp_init) begin
               chk("bp_accept_init", rif.res_init, snap.init);
               bp_follow = 1'b1;
            end
            if (sb.size() == 0) begin
               chk("sb_underflow", 1, 0);
            end else begin
               e = sb.pop_front();
               chk("res_init",  rif.res_init,  e.init);
               chk("res_kind",  rif.res_kind,  e.kind);
               chk("res_steps", rif.res_steps, e.steps);
               chk("res_attr",  rif.res_attr,  e.attr);
            end
            results++;
         end
         if (done) begin
            done_cnt++;
            finished = 1'b1;
         end
      end
      start = 1'b0;
      if (!finished) chk("sweep_timeout", 0, 1);
      repeat (3) begin
         @(negedge clk);
         if (done) done_cnt++;
         chk("busy_after", busy, 0);
      end
      chk("done_pulses", done_cnt, 1);
      chk("result_count", results, 256);
      chk("sb_left", sb.size(), 0);
      if (bp_init >= 0) chk("bp_cycles", bp_cnt, 5);
`ifdef ATTRACTOR_STATS_EN
      chk("cnt_fixed",   cnt_fixed,   (m == 0) ? 256 : 0);
      chk("cnt_cycle",   cnt_cycle,   (m == 1) ? 256 : 0);
      chk("cnt_timeout", cnt_timeout, (m == 2) ? 256 : 0);
`endif
   endtask

   initial begin
      rst           = 1'b1;
      start         = 1'b0;
      mode          = 0;
      rif.res_ready = 1'b0;
      #1;
      chk_reset_outputs("reset");
      repeat (2) @(negedge clk);
      rst = 1'b0;

      run_sweep(0, -1, -1);    // identity: all fixed points, steps=1
      run_sweep(1, -1, -1);    // inverter: all 2-cycles, steps=2
      run_sweep(2, -1, -1);    // incrementer: all timeouts at 16 steps
      run_sweep(0, 3, -1);     // backpressure on result 0x03
      run_sweep(2, -1, 128);   // reset mid-RUN at 0x80
      chk("post_abort_busy", busy, 0);
      run_sweep(0, -1, -1);    // fresh sweep must restart at 0x00

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/attractor_sweep_ctrl.md
Name: attractor_sweep_ctrl

Overview:
- Sequences the 8-gene Boolean network datapath through every initial state, 0x00 to 0xFF.
- For each initial state: loads it, steps the network until it finds a fixed point or a 2-cycle, or until a step budget runs out.
- Reports one classified result per initial state over a valid/ready handshake.
- Sits between the network state register and the result logger/display.

Parameters:
- N_GENES, 8, state width in bits; the sweep covers 2^N_GENES initial states.
- MAX_STEPS, 16, step budget per initial state before classifying as timeout.
- STEP_W, $clog2(MAX_STEPS+1), width of the step counter and of res_steps.

Ports:
- clk  in  1  system clock; all state changes on the posedge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a sweep; ignored while busy.
- net_load  out  1  network loads net_init on the next posedge.
- net_init  out  N_GENES  initial state presented with net_load.
- net_en  out  1  network advances one step on the next posedge.
- net_state  in  N_GENES  network's current registered state x[t].
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts the result.
- res_init  out  N_GENES  initial state of this result.
- res_attr  out  N_GENES  net_state at the detection cycle.
- res_kind  out  2  01 fixed point, 10 2-cycle, 11 timeout (00 never driven while valid).
- res_steps  out  STEP_W  net_en pulses issued before detection.
- busy  out  1  sweep in progress.
- done  out  1  one-cycle pulse after the last result is accepted.

Behaviour:
- Reset (async, rst=1): FSM to IDLE; all outputs 0; cur_init, step, s1, s2 cleared. Reset mid-sweep abandons the sweep, and no partial result is kept.
- FSM states: IDLE, LOAD, SETTLE, RUN, REPORT, DONE.
- IDLE: when start=1, set cur_init=0, busy=1, go to LOAD.
- LOAD (1 cycle): net_load=1, net_init=cur_init, step=0. Go to SETTLE.
- SETTLE (1 cycle): net_state now equals cur_init. Capture s1=net_state. Assert net_en, step=1, go to RUN.
- RUN, each cycle, compare net_state against history in this priority order:
  - Fixed: net_state==s1 → kind=01.
  - 2-cycle: step>=2, net_state==s2 and net_state!=s1 → kind=10.
  - Timeout: step==MAX_STEPS → kind=11.
- RUN on any detection: net_en=0 in that cycle. Latch res_attr=net_state, res_steps=step, res_kind. Go to REPORT.
- RUN otherwise: s2<=s1, s1<=net_state, net_en=1, step<=step+1.
- Periodic attractors with period >2 are classified as timeout by design.
- REPORT: res_valid=1; all res_* fields held stable until res_valid && res_ready. net_en and net_load stay 0 during backpressure.
  - On acceptance with cur_init==all-ones: go to DONE.
  - On acceptance otherwise: cur_init<=cur_init+1, go to LOAD.
- DONE (1 cycle): done=1, busy=0, go to IDLE.
- Latency: identity network gives 4 cycles from LOAD to res_valid (LOAD, SETTLE, RUN, REPORT). A 256-state sweep with zero backpressure is deterministic in length.
- start asserted in DONE or in any busy state is ignored.
- cur_init increments without overflow; the all-ones check terminates the sweep.

Optional Feature:
- Macro: ATTRACTOR_STATS_EN.
- Defined:
  - Adds outputs cnt_fixed, cnt_cycle, cnt_timeout, each N_GENES+1 bits.
  - Each increments on acceptance of a result of its kind.
  - All three clear on start and on rst.
  - After a full sweep, cnt_fixed + cnt_cycle + cnt_timeout == 2^N_GENES.
- Undefined: these ports and their counters do not exist.

Decomposition:
- Package gene_net_pkg holds:
  - N_GENES default.
  - kind_t enum: KIND_NONE=00, KIND_FIXED=01, KIND_CYCLE=10, KIND_TIMEOUT=11.
  - FSM state enum.
- One natural sub-module, attractor_detect: owns the s1/s2 history, the step counter and the three comparisons, and outputs hit and kind. The FSM stays in the top.

Test Plan:
- Identity network (x'=x), start → 256 results in init order. Each: kind=01, steps=1, attr=init. Then done pulses once.
- Inverter network (x'=~x), init 0x00 → kind=10, steps=2, attr=0x00. Init 0x5A → kind=10, attr=0x5A.
- Incrementer network (x'=x+1), init 0x10 → kind=11, steps=16, attr=0x20.
- Backpressure: hold res_ready=0 for 5 cycles on result 0x03. Check res_* stable, net_en=0 and net_load=0 throughout. Accept → next LOAD has net_init=0x04.
- Assert rst mid-RUN at init 0x80 → outputs 0 immediately, FSM to IDLE. A new start resumes from 0x00.
- With ATTRACTOR_STATS_EN, inverter network full sweep → cnt_cycle=256, cnt_fixed=0, cnt_timeout=0.
